// File: rtl/vx_gbar_multi_unit_pkg.sv
// rtl/vx_gbar_multi_unit_pkg.sv - shared widths and per-barrier state record for the global barrier unit
package vx_gbar_multi_unit_pkg;

  localparam int GBAR_NUM_BARRIERS = 8;
  localparam int GBAR_NUM_CORES    = 16;
  localparam int GBAR_ID_W         = $clog2(GBAR_NUM_BARRIERS);
  localparam int GBAR_CID_W        = $clog2(GBAR_NUM_CORES);

  typedef struct packed {
    logic [GBAR_NUM_CORES-1:0] mask;
    logic [GBAR_CID_W:0]       count;
    logic [GBAR_CID_W-1:0]     size_m1;
  } gbar_state_t;

endpackage

// File: rtl/vx_gbar_multi_unit_queue.sv
// rtl/vx_gbar_multi_unit_queue.sv - release FIFO; head is read straight from flops so the output is registered
module VX_fifo_queue #(
  parameter int DATAW = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int ADDRW = $clog2(DEPTH);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [ADDRW-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDRW:0]   count_q;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (ADDRW+1)'(DEPTH));
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (ADDRW+1)'(push_en) - (ADDRW+1)'(pop_en);
    end
  end

endmodule

// File: rtl/vx_gbar_multi_unit.sv
// rtl/vx_gbar_multi_unit.sv - multi-barrier arrival tracker with duplicate detection and a backpressured release queue
module vx_gbar_multi_unit
  import vx_gbar_multi_unit_pkg::*;
#(
  parameter int    NUM_BARRIERS = GBAR_NUM_BARRIERS,
  parameter int    NUM_CORES    = GBAR_NUM_CORES,
  parameter int    RSP_DEPTH    = 4,
  parameter string INSTANCE_ID  = ""
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  input  logic [$clog2(NUM_BARRIERS)-1:0] req_id,
  input  logic [$clog2(NUM_CORES)-1:0]    req_size_m1,
  input  logic [$clog2(NUM_CORES)-1:0]    req_core_id,
  output logic                            req_ready,
  output logic                            rsp_valid,
  output logic [$clog2(NUM_BARRIERS)-1:0] rsp_id,
  input  logic                            rsp_ready,
  output logic                            dup_err,
  output logic                            busy
);

  localparam int ID_W  = $clog2(NUM_BARRIERS);
  localparam int CID_W = $clog2(NUM_CORES);

  // The state record is sized from the package, so the core count must match it.
  if (NUM_CORES != GBAR_NUM_CORES) begin : g_bad_cores
    $error("NUM_CORES must equal GBAR_NUM_CORES");
  end

  gbar_state_t         state_q [NUM_BARRIERS];
  gbar_state_t         state_d [NUM_BARRIERS];
  gbar_state_t         cur, nxt;
  logic                dup_q, dup_d, busy_q;
  logic                fire, push, any_mask;
  logic                q_empty, q_full;
  logic [CID_W-1:0]    size_eff;

  assign fire      = req_valid & req_ready;
  assign req_ready = ~reset & ~q_full;
  assign cur       = state_q[req_id];
  assign size_eff  = (cur.mask == '0) ? req_size_m1 : cur.size_m1;

  always_comb begin
    state_d = state_q;
    dup_d   = 1'b0;
    push    = 1'b0;
    nxt     = cur;
    if (fire) begin
      if (cur.mask[req_core_id]) begin
        dup_d = 1'b1;
      end else begin
        nxt.mask[req_core_id] = 1'b1;
        nxt.count             = cur.count + 1'b1;
        nxt.size_m1           = size_eff;
        // Completing arrival re-arms the slot in the same cycle it is queued.
        if (nxt.count == {1'b0, size_eff} + (CID_W+1)'(1)) begin
          push      = 1'b1;
          nxt.mask  = '0;
          nxt.count = '0;
        end
        state_d[req_id] = nxt;
      end
    end
  end

  always_comb begin
    any_mask = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      any_mask = any_mask | (|state_q[b].mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= '0;
      end
      dup_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dup_q   <= dup_d;
      busy_q  <= any_mask | ~q_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fire && cur.mask != '0 && !cur.mask[req_core_id]) begin
      assert (req_size_m1 == cur.size_m1)
        else $error("%s: size_m1 mismatch on barrier %0d", INSTANCE_ID, req_id);
    end
  end

  VX_fifo_queue #(
    .DATAW (ID_W),
    .DEPTH (RSP_DEPTH)
  ) rsp_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (rsp_valid & rsp_ready),
    .data_i  (req_id),
    .data_o  (rsp_id),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign rsp_valid = ~q_empty;
  assign dup_err   = dup_q;
  assign busy      = busy_q;

endmodule
